// File: rtl/fpu_alu_arbiter.sv
// fpu_alu_arbiter
// Round-robin arbiter and sequencer sharing one FpuAluExecElement among
// NUM_REQ requesters. One operation is in flight at a time: grant, hold the
// element in start reset with stable operands, wait for completion, then
// present the tagged result on a single response channel.
//
// Optional build macro: FPU_ARB_TIMEOUT_EN
//   defined   -> WAIT is bounded by TIMEOUT cycles; an expired wait returns
//                resp_data=0 with resp_error=1.
//   undefined -> no wait counter; resp_error is constant 0 and WAIT waits
//                indefinitely for elem_completed.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | element held in reset, arbitrating; req_ready = winner one-hot
// START  | operands latched, elem_reset held high for START_CYCLES cycles
// WAIT   | element running, waiting for elem_completed (or timeout)
// RESP   | resp_valid high, result/id/operands held until resp_ready
module fpu_alu_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int START_CYCLES = 2,
   parameter int TIMEOUT      = 256
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [6*NUM_REQ-1:0]          req_inst_num,
   input  logic [32*NUM_REQ-1:0]         req_fs,
   input  logic [32*NUM_REQ-1:0]         req_ft,
   output logic                          resp_valid,
   input  logic                          resp_ready,
   output logic [$clog2(NUM_REQ)-1:0]    resp_id,
   output logic [31:0]                   resp_data,
   output logic                          resp_error,
   output logic                          elem_reset,
   output logic [5:0]                    elem_inst_num,
   output logic [31:0]                   elem_fs,
   output logic [31:0]                   elem_ft,
   input  logic                          elem_completed,
   input  logic [31:0]                   elem_out
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam int SCW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
   localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);
   localparam logic [SCW-1:0] START_END = SCW'(START_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t           state;
   logic [IDW-1:0]   rr_ptr;
   logic [SCW-1:0]   start_cnt;
   logic [IDW-1:0]   winner;
   logic [IDW-1:0]   scan_idx;
   logic             found;

`ifdef FPU_ARB_TIMEOUT_EN
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] WAIT_END = TW'(TIMEOUT - 1);
   logic [TW-1:0]    wait_cnt;
   logic             resp_error_q;

   assign resp_error = resp_error_q;
`else
   // Without the timeout there is no error source at all.
   assign resp_error = 1'b0;
`endif

   // First valid requester scanning upward from rr_ptr with wrap-around.
   always_comb begin
      found    = 1'b0;
      winner   = '0;
      scan_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
         if (!found && req_valid[scan_idx]) begin
            found  = 1'b1;
            winner = scan_idx;
         end
      end
   end

   // Grant is offered only in IDLE and is forced low while reset is asserted,
   // so every output shows its reset value during reset.
   always_comb begin
      req_ready = '0;
      if (reset && (state == S_IDLE) && found) begin
         req_ready[winner] = 1'b1;
      end
   end

   // Sequencer: grant, start pulse, wait for the element, hand back the result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= S_IDLE;
         rr_ptr        <= '0;
         start_cnt     <= '0;
         resp_valid    <= 1'b0;
         resp_id       <= '0;
         resp_data     <= '0;
         elem_reset    <= 1'b1;
         elem_inst_num <= '0;
         elem_fs       <= '0;
         elem_ft       <= '0;
`ifdef FPU_ARB_TIMEOUT_EN
         wait_cnt      <= '0;
         resp_error_q  <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               elem_reset <= 1'b1;
               // found implies req_valid[winner] & req_ready[winner]
               if (found) begin
                  elem_inst_num <= req_inst_num[int'(winner)*6 +: 6];
                  elem_fs       <= req_fs[int'(winner)*32 +: 32];
                  elem_ft       <= req_ft[int'(winner)*32 +: 32];
                  resp_id       <= winner;
                  rr_ptr        <= (winner == LAST_ID) ? '0 : winner + 1'b1;
                  start_cnt     <= '0;
                  state         <= S_START;
               end
            end

            S_START: begin
               if (start_cnt == START_END) begin
                  elem_reset <= 1'b0;
                  state      <= S_WAIT;
`ifdef FPU_ARB_TIMEOUT_EN
                  wait_cnt   <= '0;
`endif
               end else begin
                  start_cnt <= start_cnt + 1'b1;
               end
            end

            S_WAIT: begin
               // A completion seen on the last allowed cycle beats the timeout.
               if (elem_completed) begin
                  resp_data  <= elem_out;
                  resp_valid <= 1'b1;
                  state      <= S_RESP;
`ifdef FPU_ARB_TIMEOUT_EN
                  resp_error_q <= 1'b0;
               end else if (wait_cnt == WAIT_END) begin
                  resp_data    <= '0;
                  resp_error_q <= 1'b1;
                  resp_valid   <= 1'b1;
                  state        <= S_RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
`endif
               end
            end

            S_RESP: begin
               // elem_reset stays low so the element keeps its result stable.
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  elem_reset <= 1'b1;
                  state      <= S_IDLE;
               end
            end

            default: begin
               state      <= S_IDLE;
               elem_reset <= 1'b1;
               resp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_alu_arbiter.sv
// Self-checking bench for fpu_alu_arbiter: directed scenarios followed by
// randomized traffic, checked against a round-robin reference model and a
// behavioural stub of the execution element.
module tb_fpu_alu_arbiter;

   localparam int N  = 4;
   localparam int SC = 2;
`ifdef FPU_ARB_TIMEOUT_EN
   localparam int TO = 16;
`else
   localparam int TO = 256;
`endif

   logic              clk;
   logic              reset;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [6*N-1:0]    req_inst_num;
   logic [32*N-1:0]   req_fs;
   logic [32*N-1:0]   req_ft;
   logic              resp_valid;
   logic              resp_ready;
   logic [1:0]        resp_id;
   logic [31:0]       resp_data;
   logic              resp_error;
   logic              elem_reset;
   logic [5:0]        elem_inst_num;
   logic [31:0]       elem_fs;
   logic [31:0]       elem_ft;
   logic              elem_completed = 1'b0;
   logic [31:0]       elem_out = '0;

   fpu_alu_arbiter #(
      .NUM_REQ(N), .START_CYCLES(SC), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_inst_num(req_inst_num), .req_fs(req_fs), .req_ft(req_ft),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_id(resp_id), .resp_data(resp_data), .resp_error(resp_error),
      .elem_reset(elem_reset), .elem_inst_num(elem_inst_num),
      .elem_fs(elem_fs), .elem_ft(elem_ft),
      .elem_completed(elem_completed), .elem_out(elem_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Known element results, otherwise an arbitrary mixing function.
   function automatic logic [31:0] elem_fn(input logic [5:0] i, input logic [31:0] a, input logic [31:0] b);
      if (i == 6'd56 && a == 32'h4048f5c3 && b == 32'h411ffbe7) return 32'h41523958;
      if (i == 6'd58 && a == 32'h4048f5c3 && b == 32'h411ffbe7) return 32'h41fb2cc5;
      if (i == 6'd59 && a == 32'h4048f5c3 && b == 32'h411ffbe7) return 32'h3ea0c8ba;
      if (i == 6'd54 && a == 32'hffffffff && b == 32'h0)        return 32'h7fffffff;
      if (i == 6'd60 && a == 32'h0012d687 && b == 32'h0)        return 32'h4996b438;
      return a ^ {b[15:0], b[31:16]} ^ {26'd0, i} ^ 32'h5a5a0000;
   endfunction

   // Element stub: completion lat_cfg cycles after start reset drops.
   int lat_cfg = 1;
   bit stuck   = 1'b0;
   int lat_cnt = 0;
   always @(posedge clk) begin
      if (elem_reset) begin
         lat_cnt        <= 0;
         elem_completed <= 1'b0;
      end else if (!elem_completed) begin
         if (!stuck && lat_cnt >= lat_cfg) begin
            elem_completed <= 1'b1;
            elem_out       <= elem_fn(elem_inst_num, elem_fs, elem_ft);
         end else begin
            lat_cnt <= lat_cnt + 1;
         end
      end
   end

   int ntests = 0;
   int nfail  = 0;
   int ptr    = 0;
   logic [5:0]  m_inst [N];
   logic [31:0] m_fs   [N];
   logic [31:0] m_ft   [N];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [5:0] inst, input logic [31:0] fs, input logic [31:0] ft);
      m_inst[i] = inst;
      m_fs[i]   = fs;
      m_ft[i]   = ft;
      req_inst_num[i*6 +: 6] = inst;
      req_fs[i*32 +: 32]     = fs;
      req_ft[i*32 +: 32]     = ft;
      req_valid[i]           = 1'b1;
   endtask

   // Reference arbitration: first valid index from ptr upward with wrap.
   function automatic int pick();
      for (int k = 0; k < N; k++) begin
         if (req_valid[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic check_reset_outputs(input string nm);
      chk({nm, "_req_ready"},  req_ready, 0);
      chk({nm, "_resp_valid"}, resp_valid, 0);
      chk({nm, "_resp_id"},    resp_id, 0);
      chk({nm, "_resp_data"},  resp_data, 0);
      chk({nm, "_resp_error"}, resp_error, 0);
      chk({nm, "_elem_reset"}, elem_reset, 1);
      chk({nm, "_elem_inst"},  elem_inst_num, 0);
      chk({nm, "_elem_fs"},    elem_fs, 0);
      chk({nm, "_elem_ft"},    elem_ft, 0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      check_reset_outputs("reset");
      tick();
      reset = 1'b1;
      ptr   = 0;
      tick();
   endtask

   // One full operation. hold<0: resp_ready raised before the response.
   task automatic do_txn(input string nm, input int hold, input bit drop);
      int e;
      int g;
      logic [31:0] exp_d;
      #1;
      if (hold < 0) resp_ready = 1'b1;
      g = 0;
      while (req_ready == '0 && g < 50) begin
         tick();
         g++;
      end
      e = pick();
      if (req_ready == '0 || e < 0) begin
         chk({nm, "_grant_seen"}, req_ready != '0, 1);
         resp_ready = 1'b0;
         return;
      end
      chk({nm, "_grant"}, req_ready, 64'(1) << e);
      chk({nm, "_idle_elem_reset"}, elem_reset, 1);
      exp_d = elem_fn(m_inst[e], m_fs[e], m_ft[e]);
      ptr   = (e + 1) % N;
      for (int s = 0; s < SC; s++) begin
         tick();
         if (s == 0 && drop) req_valid[e] = 1'b0;
         chk({nm, "_start_elem_reset"}, elem_reset, 1);
         chk({nm, "_start_no_grant"}, req_ready, 0);
      end
      tick();
      chk({nm, "_wait_elem_reset"}, elem_reset, 0);
      chk({nm, "_elem_inst"}, elem_inst_num, m_inst[e]);
      chk({nm, "_elem_fs"}, elem_fs, m_fs[e]);
      chk({nm, "_elem_ft"}, elem_ft, m_ft[e]);
      g = 0;
      while (!resp_valid && g < 300) begin
         tick();
         g++;
      end
      chk({nm, "_resp_valid"}, resp_valid, 1);
      if (!resp_valid) begin
         resp_ready = 1'b0;
         return;
      end
      chk({nm, "_resp_id"}, resp_id, e);
      chk({nm, "_resp_data"}, resp_data, exp_d);
      chk({nm, "_resp_error"}, resp_error, 0);
      chk({nm, "_resp_no_grant"}, req_ready, 0);
      for (int h = 0; h < hold; h++) begin
         tick();
         chk({nm, "_hold_valid"}, resp_valid, 1);
         chk({nm, "_hold_data"}, resp_data, exp_d);
         chk({nm, "_hold_id"}, resp_id, e);
         chk({nm, "_hold_elem_reset"}, elem_reset, 0);
         chk({nm, "_hold_no_grant"}, req_ready, 0);
      end
      resp_ready = 1'b1;
      tick();
      chk({nm, "_resp_done"}, resp_valid, 0);
      chk({nm, "_back_elem_reset"}, elem_reset, 1);
      resp_ready = 1'b0;
   endtask

   initial begin
      int cnt;
      bit seen;
      reset        = 1'b0;
      req_valid    = '0;
      req_inst_num = '0;
      req_fs       = '0;
      req_ft       = '0;
      resp_ready   = 1'b0;
      for (int i = 0; i < N; i++) begin
         m_inst[i] = '0;
         m_fs[i]   = '0;
         m_ft[i]   = '0;
      end
      tick();
      do_reset();

      // single requester
      lat_cfg = 2;
      set_req(0, 6'd56, 32'h4048f5c3, 32'h411ffbe7);
      do_txn("t1", 0, 1'b1);

      // two simultaneous requesters right after reset
      do_reset();
      set_req(0, 6'd58, 32'h4048f5c3, 32'h411ffbe7);
      set_req(2, 6'd59, 32'h4048f5c3, 32'h411ffbe7);
      do_txn("t2a", 0, 1'b1);
      do_txn("t2b", 0, 1'b1);

      // all requesters continuously valid, including pointer wrap
      lat_cfg = 0;
      for (int i = 0; i < N; i++) set_req(i, 6'd54, 32'hffffffff, 32'h0);
      for (int k = 0; k < 5; k++) do_txn("t3", (k == 2) ? -1 : 0, 1'b0);
      req_valid = '0;

      // response back-pressure
      lat_cfg = 3;
      set_req(1, 6'd60, 32'h0012d687, 32'h0);
      do_txn("t4", 5, 1'b1);

      // reset while waiting on req3
      lat_cfg = 50;
      set_req(3, 6'd57, 32'h3f800000, 32'h40000000);
      #1;
      cnt = 0;
      while (req_ready == '0 && cnt < 50) begin tick(); cnt++; end
      chk("t5_grant", req_ready, 4'b1000);
      for (int s = 0; s < SC + 1; s++) tick();
      chk("t5_in_wait", elem_reset, 0);
      reset = 1'b0;
      #1;
      check_reset_outputs("t5");
      tick();
      reset   = 1'b1;
      ptr     = 0;
      lat_cfg = 1;
      do_txn("t5_regrant", 1, 1'b1);

      // randomized traffic
      for (int it = 0; it < 25; it++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && $urandom_range(0, 1) == 1)
               set_req(i, 6'($urandom), $urandom, $urandom);
         end
         if (req_valid == '0) set_req($urandom_range(0, N - 1), 6'($urandom), $urandom, $urandom);
         lat_cfg = $urandom_range(0, 4);
         do_txn("rnd", ($urandom_range(0, 4) == 0) ? -1 : $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
      req_valid = '0;

      // element never completes
      do_reset();
      stuck = 1'b1;
      set_req(1, 6'd3, 32'h1, 32'h2);
      #1;
      cnt = 0;
      while (req_ready == '0 && cnt < 50) begin tick(); cnt++; end
      chk("t6_grant", req_ready, 4'b0010);
      tick();
      req_valid = '0;
      cnt = 0;
      while (elem_reset && cnt < 20) begin tick(); cnt++; end
      chk("t6_wait_entry", elem_reset, 0);
`ifdef FPU_ARB_TIMEOUT_EN
      cnt = 0;
      while (!resp_valid && cnt < 100) begin tick(); cnt++; end
      chk("t6_timeout_cycles", cnt, 16);
      chk("t6_resp_valid", resp_valid, 1);
      chk("t6_resp_error", resp_error, 1);
      chk("t6_resp_data", resp_data, 0);
      chk("t6_resp_id", resp_id, 1);
      resp_ready = 1'b1;
      tick();
      chk("t6_resp_done", resp_valid, 0);
      resp_ready = 1'b0;
`else
      seen = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         tick();
         if (resp_valid) seen = 1'b1;
      end
      chk("t6_no_response", seen, 0);
      chk("t6_error_tied", resp_error, 0);
`endif
      stuck = 1'b0;
      do_reset();

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
